video_pattern_gen: RTL

AXI4-Stream video source for 1920x1080 24-bit RGB that produces complete frames of a selectable test pattern. Sits directly upstream of the stream-to-RGB timing stage, driving its slave stream port (tuser = start of frame, tlast = end of line). It gives the display path a known-good source for bring-up and for regression without a camera or DMA.

---
 rtl/video_pkg.sv | 40 ++++
 rtl/video_pattern_pixel.sv | 35 +++
 rtl/video_pattern_gen.sv | 110 +++++++++++
 3 files changed

// File: rtl/video_pkg.sv
// Shared constants for the video test-pattern source: default geometry,
// pattern selects, the eight colour-bar values and the FSM encoding.
package video_pkg;

    localparam int H_ACTIVE_DEF = 1920;
    localparam int V_ACTIVE_DEF = 1080;

    localparam logic [1:0] PAT_BARS  = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_CHECK = 2'd2;
    localparam logic [1:0] PAT_SOLID = 2'd3;

    localparam logic [23:0] BAR_WHITE   = 24'hFFFFFF;
    localparam logic [23:0] BAR_YELLOW  = 24'hFFFF00;
    localparam logic [23:0] BAR_CYAN    = 24'h00FFFF;
    localparam logic [23:0] BAR_GREEN   = 24'h00FF00;
    localparam logic [23:0] BAR_MAGENTA = 24'hFF00FF;
    localparam logic [23:0] BAR_RED     = 24'hFF0000;
    localparam logic [23:0] BAR_BLUE    = 24'h0000FF;
    localparam logic [23:0] BAR_BLACK   = 24'h000000;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    function automatic logic [23:0] bar_color(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational pattern lookup: pattern coordinate (xs, y) and select -> pixel.
module video_pattern_pixel
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int DATA_W   = 24
) (
    input  logic [10:0]       xs,
    input  logic [10:0]       y,
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] solid,
    output logic [DATA_W-1:0] pixel
);

    localparam int BAR_W = H_ACTIVE / 8;

    logic [2:0] bar_idx;

    // Threshold compare chain stands in for xs / BAR_W
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++)
            if (int'(xs) >= k * BAR_W) bar_idx = 3'(k);
    end

    always_comb begin
        case (sel)
            PAT_BARS:  pixel = DATA_W'(bar_color(bar_idx));
            PAT_RAMP:  pixel = DATA_W'({3{xs[10:3]}});
            PAT_CHECK: pixel = (xs[6] ^ y[6]) ? DATA_W'(24'hFFFFFF) : '0;
            default:   pixel = solid;
        endcase
    end

endmodule

// File: rtl/video_pattern_gen.sv
// AXI4-Stream test-pattern frame source. Optional horizontal scroll of
// patterns 0-2 by one pixel per frame under VIDEO_PATTERN_SCROLL_EN.
module video_pattern_gen
    import video_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int DATA_W   = 24
) (
    input  logic              aclk,
    input  logic              areset,
    input  logic              enable,
    input  logic [1:0]        pattern_sel,
    input  logic [DATA_W-1:0] solid_color,
    output logic              axis_m_tvalid,
    input  logic              axis_m_tready,
    output logic [DATA_W-1:0] axis_m_tdata,
    output logic              axis_m_tuser,
    output logic              axis_m_tlast,
    output logic [15:0]       frame_count,
    output logic              busy
);

    localparam logic [10:0] X_LAST = 11'(H_ACTIVE - 1);
    localparam logic [10:0] Y_LAST = 11'(V_ACTIVE - 1);

    state_t            state;
    logic [10:0]       x, y, px, py, xs;
    logic [1:0]        sel_q, psel;
    logic [DATA_W-1:0] solid_q, psolid, pix;
    logic              fire, eol, eof, last_acc, start, load;

    assign fire     = axis_m_tvalid & axis_m_tready;
    assign eol      = (x == X_LAST);
    assign eof      = eol && (y == Y_LAST);
    assign last_acc = (state == ST_ACTIVE) && fire && eof;
    // A frame starts from IDLE or immediately after the previous one's last beat
    assign start    = (state == ST_IDLE) ? enable : (last_acc && enable);
    assign load     = start || ((state == ST_ACTIVE) && fire && !eof);
    assign busy     = (state == ST_ACTIVE);

    // Coordinates and selects of the beat that will be registered on a load
    always_comb begin
        px     = start ? 11'd0 : (eol ? 11'd0 : x + 11'd1);
        py     = start ? 11'd0 : (eol ? y + 11'd1 : y);
        psel   = start ? pattern_sel : sel_q;
        psolid = start ? solid_color : solid_q;
    end

`ifdef VIDEO_PATTERN_SCROLL_EN
    // off_q tracks frame_count mod H_ACTIVE, so it needs no divider
    logic [10:0] off_q, off_inc, poff;
    logic [11:0] xsum;

    assign off_inc = (off_q == X_LAST) ? 11'd0 : off_q + 11'd1;
    assign poff    = last_acc ? off_inc : off_q;
    assign xsum    = {1'b0, px} + {1'b0, poff};
    assign xs      = (xsum >= 12'(H_ACTIVE)) ? 11'(xsum - 12'(H_ACTIVE)) : xsum[10:0];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset)        off_q <= '0;
        else if (last_acc) off_q <= off_inc;
    end
`else
    assign xs = px;
`endif

    video_pattern_pixel #(.H_ACTIVE(H_ACTIVE), .DATA_W(DATA_W)) u_pixel (
        .xs    (xs),
        .y     (py),
        .sel   (psel),
        .solid (psolid),
        .pixel (pix)
    );

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state         <= ST_IDLE;
            x             <= '0;
            y             <= '0;
            sel_q         <= PAT_BARS;
            solid_q       <= '0;
            frame_count   <= '0;
            axis_m_tvalid <= 1'b0;
            axis_m_tdata  <= '0;
            axis_m_tuser  <= 1'b0;
            axis_m_tlast  <= 1'b0;
        end else begin
            if (last_acc) frame_count <= frame_count + 16'd1;
            if (load) begin
                state         <= ST_ACTIVE;
                x             <= px;
                y             <= py;
                sel_q         <= psel;
                solid_q       <= psolid;
                axis_m_tvalid <= 1'b1;
                axis_m_tdata  <= pix;
                axis_m_tuser  <= (px == 11'd0) && (py == 11'd0);
                axis_m_tlast  <= (px == X_LAST);
            end else if (last_acc) begin
                state         <= ST_IDLE;
                axis_m_tvalid <= 1'b0;
                axis_m_tdata  <= '0;
                axis_m_tuser  <= 1'b0;
                axis_m_tlast  <= 1'b0;
            end
        end
    end

endmodule
